// File: rtl/bsg_manycore_boot_pkg.sv
// bsg_manycore_boot_pkg: shared opcode/state encodings and ROM word layout for the boot loader
`ifndef BSG_MANYCORE_BOOT_WORD_S
`define BSG_MANYCORE_BOOT_WORD_S(w) struct packed { logic [bsg_manycore_boot_pkg::op_width_lp-1:0] op; logic [(w)-1:0] payload; }
`endif
package bsg_manycore_boot_pkg;
  localparam int op_width_lp = 4;
  typedef enum logic [op_width_lp-1:0] {
    OP_NOP  = 4'd0,
    OP_SEND = 4'd1,
    OP_RECV = 4'd2,
    OP_WAIT = 4'd3,
    OP_DONE = 4'd4
  } opcode_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE, ST_ERROR} state_e;
endpackage

// File: rtl/bsg_manycore_boot_wait_counter.sv
// bsg_manycore_boot_wait_counter: loadable down-counter that stops at zero
//   clk_i, reset_i : clock, asynchronous active-high reset (count clears to 0)
//   load_i         : load count_i (takes priority over en_i)
//   en_i           : decrement by one when not already zero
//   count_i        : value to load
//   zero_o         : count is zero
module bsg_manycore_boot_wait_counter #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [width_p-1:0] count_i,
  output logic               zero_o
);
  logic [width_p-1:0] cnt_r;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) cnt_r <= '0;
    else if (load_i) cnt_r <= count_i;
    else if (en_i && !zero_o) cnt_r <= cnt_r - 1'b1;
  assign zero_o = cnt_r == '0;
endmodule

// File: rtl/bsg_manycore_boot_loader.sv
// bsg_manycore_boot_loader: replays a ROM boot program (send/recv/wait/nop/done) onto the FSB ring
//   clk_i, reset_i       : clock, asynchronous active-high reset
//   en_i                 : enable; low freezes all state and drops v_o/ready_o
//   rom_addr_o/rom_data_i: combinational ROM port, address is the program counter
//   v_i/data_i/ready_o   : inbound packet for RECV comparison
//   v_o/data_o/yumi_i    : outbound packet for SEND
//   done_o, error_o      : sticky status
// Optional: define BSG_MANYCORE_BOOT_LOADER_TIMEOUT_EN to abort SEND/RECV stalls after timeout_p cycles.
module bsg_manycore_boot_loader
  import bsg_manycore_boot_pkg::*;
#(
  parameter int ring_width_p     = 76,
  parameter int rom_addr_width_p = 10,
  parameter int wait_width_p     = 16,
  parameter int timeout_p        = 1024
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                en_i,
  output logic [rom_addr_width_p-1:0]         rom_addr_o,
  input  logic [op_width_lp+ring_width_p-1:0] rom_data_i,
  input  logic                                v_i,
  input  logic [ring_width_p-1:0]             data_i,
  output logic                                ready_o,
  output logic                                v_o,
  output logic [ring_width_p-1:0]             data_o,
  input  logic                                yumi_i,
  output logic                                done_o,
  output logic                                error_o
);
  typedef `BSG_MANYCORE_BOOT_WORD_S(ring_width_p) word_s;
  word_s word;
  state_e state_r, state_n;
  logic [rom_addr_width_p-1:0] pc_r;
  logic [wait_width_p-1:0] n;
  logic run, adv, wait_zero;
  assign word = rom_data_i;
  assign n = word.payload[wait_width_p-1:0];
  assign run = en_i && state_r == ST_RUN;
  assign rom_addr_o = pc_r;
  assign v_o = run && word.op == OP_SEND;
  assign ready_o = run && word.op == OP_RECV;
  assign data_o = word.payload;
  assign done_o = state_r == ST_DONE;
  assign error_o = state_r == ST_ERROR;
  // Loaded with N-1 so the N WAIT-state cycles plus the decode cycle total N+1.
  bsg_manycore_boot_wait_counter #(.width_p(wait_width_p)) wait_cnt (
    .clk_i,
    .reset_i,
    .load_i (run && word.op == OP_WAIT && n != '0),
    .en_i   (en_i && state_r == ST_WAIT),
    .count_i(n - 1'b1),
    .zero_o (wait_zero)
  );
`ifdef BSG_MANYCORE_BOOT_LOADER_TIMEOUT_EN
  localparam int stall_w_lp = $clog2(timeout_p + 1);
  logic stall, stall_zero;
  assign stall = run && ((word.op == OP_SEND && !yumi_i) || (word.op == OP_RECV && !v_i));
  // Reloaded on every enabled non-stalled cycle; the timeout_p-th consecutive stall sees zero.
  bsg_manycore_boot_wait_counter #(.width_p(stall_w_lp)) stall_cnt (
    .clk_i,
    .reset_i,
    .load_i (en_i && !stall),
    .en_i   (stall),
    .count_i(stall_w_lp'(timeout_p - 1)),
    .zero_o (stall_zero)
  );
`endif
  always_comb begin
    state_n = state_r;
    adv = 1'b0;
    if (en_i)
      case (state_r)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN:
          case (word.op)
            OP_NOP:  adv = 1'b1;
            OP_SEND: adv = yumi_i;
            OP_RECV: begin
              adv = v_i && data_i == word.payload;
              state_n = v_i && data_i != word.payload ? ST_ERROR : state_r;
            end
            OP_WAIT: begin
              adv = n == '0;
              state_n = n == '0 ? state_r : ST_WAIT;
            end
            OP_DONE: state_n = ST_DONE;
            default: state_n = ST_ERROR;
          endcase
        ST_WAIT: begin
          adv = wait_zero;
          state_n = wait_zero ? ST_RUN : state_r;
        end
        default: ;
      endcase
`ifdef BSG_MANYCORE_BOOT_LOADER_TIMEOUT_EN
    if (stall && stall_zero) state_n = ST_ERROR;
`endif
    // Advancing past the last ROM word is an error rather than a wrap to 0.
    if (adv && &pc_r) state_n = ST_ERROR;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_r <= ST_IDLE;
      pc_r <= '0;
    end else begin
      state_r <= state_n;
      if (adv && !(&pc_r)) pc_r <= pc_r + 1'b1;
    end
endmodule

// File: tb/tb_bsg_manycore_boot_loader.sv
// tb_bsg_manycore_boot_loader: self-checking bench for the boot loader with a scoreboard of expected SEND payloads
module tb_bsg_manycore_boot_loader;
  import bsg_manycore_boot_pkg::*;
  localparam int rw = 76;
  localparam int aw = 10;
  logic clk = 1'b0;
  logic reset_i, en_i, v_i, yumi_i, ready_o, v_o, done_o, error_o;
  logic [aw-1:0] rom_addr_o;
  logic [rw+3:0] rom_data_i;
  logic [rw-1:0] data_i, data_o;
  logic [rw+3:0] rom [1024];
  logic [rw-1:0] sb_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign rom_data_i = rom[rom_addr_o];
  bsg_manycore_boot_loader #(.timeout_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .done_o(done_o), .error_o(error_o)
  );
  function automatic logic [rw+3:0] w(input logic [3:0] op, input logic [rw-1:0] p);
    return {op, p};
  endfunction
  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
    sb_q.delete();
  endtask
  task automatic boot();
    reset_i = 1'b1; en_i = 1'b0; yumi_i = 1'b0; v_i = 1'b0; data_i = '0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0; en_i = 1'b1;
  endtask
  task automatic step(input logic en, input logic yumi, input logic v, input logic [rw-1:0] d);
    @(negedge clk);
    en_i = en; yumi_i = yumi; v_i = v; data_i = d;
    #1;
  endtask
  task automatic test_reset();
    clear_rom();
    rom[0] = w(OP_SEND, 76'h77);
    reset_i = 1'b1; en_i = 1'b1; yumi_i = 1'b0; v_i = 1'b0; data_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({v_o, ready_o, done_o, error_o, rom_addr_o} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got v=%b r=%b d=%b e=%b a=%0d exp all 0", v_o, ready_o, done_o, error_o, rom_addr_o);
    end
    @(negedge clk); reset_i = 1'b0; en_i = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL idle_v got %b exp 0", v_o); end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 1'b1 || data_o !== 76'h77) begin errors++; $display("FAIL run_after_idle got v=%b d=%h exp v=1 d=77", v_o, data_o); end
  endtask
  task automatic test_send();
    logic [rw-1:0] exp;
    clear_rom();
    rom[0] = w(OP_SEND, 76'hA5); rom[1] = w(OP_SEND, 76'h3C); rom[2] = w(OP_DONE, '0);
    sb_q.push_back(76'hA5); sb_q.push_back(76'h3C);
    boot();
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      checks++;
      if (v_o !== (c <= 2)) begin errors++; $display("FAIL send_v cycle %0d got %b exp %b", c, v_o, c <= 2); end
      if (v_o && yumi_i) begin
        exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
        checks++;
        if (data_o !== exp) begin errors++; $display("FAIL send_data cycle %0d got %h exp %h", c, data_o, exp); end
      end
      checks++;
      if (done_o !== (c >= 4) || error_o !== 1'b0) begin
        errors++; $display("FAIL send_status cycle %0d got done=%b err=%b exp done=%b err=0", c, done_o, error_o, c >= 4);
      end
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL send_drain got %0d left exp 0", sb_q.size()); end
  endtask
  task automatic test_backpressure();
    logic [rw-1:0] exp;
    clear_rom();
    rom[0] = w(OP_SEND, 76'h11); rom[1] = w(OP_DONE, '0);
    sb_q.push_back(76'h11);
    boot();
    for (int c = 1; c <= 5; c++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      checks++;
      if (v_o !== 1'b1 || data_o !== 76'h11 || rom_addr_o !== 10'd0) begin
        errors++; $display("FAIL hold cycle %0d got v=%b d=%h a=%0d exp v=1 d=11 a=0", c, v_o, data_o, rom_addr_o);
      end
    end
    step(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (v_o !== 1'b0) begin errors++; $display("FAIL en_low_v got %b exp 0", v_o); end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 1'b1 || rom_addr_o !== 10'd0) begin errors++; $display("FAIL en_low_freeze got v=%b a=%0d exp v=1 a=0", v_o, rom_addr_o); end
    step(1'b1, 1'b1, 1'b0, '0);
    if (v_o && yumi_i) begin
      exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
      checks++;
      if (data_o !== exp) begin errors++; $display("FAIL bp_data got %h exp %h", data_o, exp); end
    end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 1'b0 || rom_addr_o !== 10'd1) begin errors++; $display("FAIL bp_advance got v=%b a=%0d exp v=0 a=1", v_o, rom_addr_o); end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (done_o !== 1'b1 || sb_q.size() != 0) begin errors++; $display("FAIL bp_done got done=%b left=%0d exp done=1 left=0", done_o, sb_q.size()); end
  endtask
  task automatic test_wait(input bit gap);
    logic [rw-1:0] exp;
    int first = 0;
    int want = gap ? 12 : 9;
    clear_rom();
    rom[0] = w(OP_WAIT, 76'd7); rom[1] = w(OP_SEND, 76'h1);
    sb_q.push_back(76'h1);
    boot();
    for (int c = 1; c <= 16; c++) begin
      step(!(gap && c >= 4 && c <= 6), 1'b1, 1'b0, '0);
      if (v_o && first == 0) first = c;
      if (v_o && yumi_i) begin
        exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
        checks++;
        if (data_o !== exp) begin errors++; $display("FAIL wait_data got %h exp %h", data_o, exp); end
      end
    end
    checks++;
    if (first != want) begin errors++; $display("FAIL wait_latency gap=%0d got cycle %0d exp %0d", gap, first, want); end
  endtask
  task automatic test_recv();
    clear_rom();
    rom[0] = w(OP_RECV, 76'h55); rom[1] = w(OP_RECV, 76'h66); rom[2] = w(OP_DONE, '0);
    boot();
    step(1'b1, 1'b0, 1'b1, 76'h55);
    checks++;
    if (ready_o !== 1'b1 || v_o !== 1'b0 || rom_addr_o !== 10'd0) begin
      errors++; $display("FAIL recv0 got r=%b v=%b a=%0d exp r=1 v=0 a=0", ready_o, v_o, rom_addr_o);
    end
    step(1'b1, 1'b0, 1'b1, 76'h67);
    checks++;
    if (ready_o !== 1'b1 || rom_addr_o !== 10'd1) begin errors++; $display("FAIL recv1 got r=%b a=%0d exp r=1 a=1", ready_o, rom_addr_o); end
    for (int c = 3; c <= 5; c++) begin
      step(1'b1, 1'b0, 1'b1, 76'h66);
      checks++;
      if (error_o !== 1'b1 || done_o !== 1'b0 || ready_o !== 1'b0 || rom_addr_o !== 10'd1) begin
        errors++; $display("FAIL recv_err cycle %0d got e=%b d=%b r=%b a=%0d exp e=1 d=0 r=0 a=1", c, error_o, done_o, ready_o, rom_addr_o);
      end
    end
  endtask
  task automatic test_illegal();
    clear_rom();
    rom[0] = w(4'd9, '0);
    boot();
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (error_o !== 1'b0) begin errors++; $display("FAIL illegal_early got %b exp 0", error_o); end
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (error_o !== 1'b1 || done_o !== 1'b0 || rom_addr_o !== 10'd0) begin
      errors++; $display("FAIL illegal got e=%b d=%b a=%0d exp e=1 d=0 a=0", error_o, done_o, rom_addr_o);
    end
  endtask
  task automatic test_reset_midsend();
    logic [rw-1:0] exp;
    clear_rom();
    rom[0] = w(OP_SEND, 76'hAA); rom[1] = w(OP_DONE, '0);
    boot();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (v_o !== 1'b1) begin errors++; $display("FAIL midsend_pre got %b exp 1", v_o); end
    @(negedge clk); reset_i = 1'b1; #1;
    checks++;
    if (v_o !== 1'b0 || rom_addr_o !== 10'd0) begin errors++; $display("FAIL midsend_reset got v=%b a=%0d exp v=0 a=0", v_o, rom_addr_o); end
    sb_q.push_back(76'hAA);
    boot();
    step(1'b1, 1'b1, 1'b0, '0);
    checks++;
    if (v_o !== 1'b1 || rom_addr_o !== 10'd0) begin errors++; $display("FAIL replay got v=%b a=%0d exp v=1 a=0", v_o, rom_addr_o); end
    if (v_o && yumi_i) begin
      exp = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
      checks++;
      if (data_o !== exp) begin errors++; $display("FAIL replay_data got %h exp %h", data_o, exp); end
    end
  endtask
  task automatic test_overflow();
    clear_rom();
    boot();
    for (int c = 1; c <= 1025; c++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (c == 1024) begin
        checks++;
        if (error_o !== 1'b0 || rom_addr_o !== 10'd1023) begin errors++; $display("FAIL ovf_last got e=%b a=%0d exp e=0 a=1023", error_o, rom_addr_o); end
      end
      if (c == 1025) begin
        checks++;
        if (error_o !== 1'b1 || rom_addr_o !== 10'd1023) begin errors++; $display("FAIL ovf_err got e=%b a=%0d exp e=1 a=1023", error_o, rom_addr_o); end
      end
    end
  endtask
  task automatic test_timeout();
    clear_rom();
    rom[0] = w(OP_SEND, 76'h2);
    boot();
`ifdef BSG_MANYCORE_BOOT_LOADER_TIMEOUT_EN
    for (int c = 1; c <= 17; c++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (c == 16) begin
        checks++;
        if (error_o !== 1'b0 || v_o !== 1'b1) begin errors++; $display("FAIL timeout_early got e=%b v=%b exp e=0 v=1", error_o, v_o); end
      end
      if (c == 17) begin
        checks++;
        if (error_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL timeout got e=%b v=%b exp e=1 v=0", error_o, v_o); end
      end
    end
`else
    for (int c = 1; c <= 1000; c++) step(1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (error_o !== 1'b0 || v_o !== 1'b1 || data_o !== 76'h2) begin
      errors++; $display("FAIL no_timeout got e=%b v=%b d=%h exp e=0 v=1 d=2", error_o, v_o, data_o);
    end
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_send();
    test_backpressure();
    test_wait(1'b0);
    test_wait(1'b1);
    test_recv();
    test_illegal();
    test_reset_midsend();
    test_overflow();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
